// File: rtl/blink_pkg.sv
// Shared definitions for the blink line monitor: state encoding and blinker-matched defaults.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Must track the LED blinker's default TOGGLE_EVERY.
    localparam int unsigned DEFAULT_EXPECTED_HALF = 3;

endpackage

// File: rtl/blink_run_timer.sv
// Edge detector and saturating run-length counter for the monitored blink line.
module blink_run_timer #(
    parameter int unsigned COUNTER_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     blink_in,
    output logic                     edge_c,
    output logic [COUNTER_WIDTH-1:0] cnt
);

    logic blink_q;

    assign edge_c = (blink_in != blink_q);

    // Counter restarts at 1 on an edge so it equals the run length at the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= 1'b0;
            cnt     <= '0;
        end else begin
            blink_q <= blink_in;
            if (edge_c) begin
                cnt <= COUNTER_WIDTH'(1);
            end else if (cnt != '1) begin
                cnt <= cnt + COUNTER_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/blink_monitor.sv
// Blink line monitor: measures run lengths, checks them against the expected
// half period, declares lock after consecutive good runs and flags a stuck line.
module blink_monitor
    import blink_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH  = 4,
    parameter int unsigned EXPECTED_HALF  = DEFAULT_EXPECTED_HALF,
    parameter int unsigned TOLERANCE      = 0,
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     blink_in,
    output logic                     locked,
    output logic [COUNTER_WIDTH-1:0] half_period,
    output logic                     period_valid,
    output logic                     mismatch,
    output logic                     stuck
);

    localparam int unsigned CW1 = COUNTER_WIDTH + 1;
    localparam int unsigned MW  = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MW1 = MW + 1;

    logic                     edge_c;
    logic [COUNTER_WIDTH-1:0] cnt;

    blink_run_timer #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_run_timer (
        .clk     (clk),
        .rst     (rst),
        .blink_in(blink_in),
        .edge_c  (edge_c),
        .cnt     (cnt)
    );

    state_t                   state_q, state_d;
    logic [MW-1:0]            match_cnt_q, match_cnt_d;
    logic [COUNTER_WIDTH-1:0] half_d;
    logic                     pv_d, mm_d, st_d;

    // Absolute deviation one bit wider than the counter so it never wraps.
    logic [CW1-1:0] cnt_x, exp_x, diff_c;
    logic           match_c, timeout_c, lock_hit_c;

    assign cnt_x      = {1'b0, cnt};
    assign exp_x      = CW1'(EXPECTED_HALF);
    assign diff_c     = (cnt_x >= exp_x) ? (cnt_x - exp_x) : (exp_x - cnt_x);
    assign match_c    = (diff_c <= CW1'(TOLERANCE));
    assign timeout_c  = (cnt == COUNTER_WIDTH'(TIMEOUT_CYCLES));
    assign lock_hit_c = (({1'b0, match_cnt_q} + MW1'(1)) == MW1'(LOCK_COUNT));

    // Next state and next output values; an edge always takes priority over timeout.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        half_d      = half_period;
        pv_d        = 1'b0;
        mm_d        = 1'b0;
        st_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_c) begin
                    state_d     = MEASURE;
                    match_cnt_d = '0;
                end
            end
            MEASURE: begin
                if (edge_c) begin
                    half_d = cnt;
                    pv_d   = 1'b1;
                    if (match_c) begin
                        match_cnt_d = match_cnt_q + MW'(1);
                        if (lock_hit_c) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        mm_d        = 1'b1;
                        match_cnt_d = '0;
                    end
                end else if (timeout_c) begin
                    st_d        = 1'b1;
                    state_d     = IDLE;
                    match_cnt_d = '0;
                end
            end
            LOCKED: begin
                if (edge_c) begin
                    half_d = cnt;
                    pv_d   = 1'b1;
                    if (!match_c) begin
                        mm_d        = 1'b1;
                        state_d     = MEASURE;
                        match_cnt_d = '0;
                    end
                end else if (timeout_c) begin
                    st_d        = 1'b1;
                    state_d     = IDLE;
                    match_cnt_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                match_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            match_cnt_q  <= '0;
            half_period  <= '0;
            period_valid <= 1'b0;
            mismatch     <= 1'b0;
            stuck        <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state_q      <= state_d;
            match_cnt_q  <= match_cnt_d;
            half_period  <= half_d;
            period_valid <= pv_d;
            mismatch     <= mm_d;
            stuck        <= st_d;
            locked       <= (state_d == LOCKED);
        end
    end

endmodule

// File: tb/tb_blink_monitor.sv
// Bench for blink_monitor: two instances (tolerance 0 and 1) on one stimulus,
// checked every cycle against a timestamp-based model plus literal spot checks.
module tb_blink_monitor;

    localparam int EXP_HALF = 3;
    localparam int LOCK_N   = 4;
    localparam int TMO      = 8;
    localparam int SAT      = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       blink_in = 1'b0;

    logic       locked0, pv0, mm0, st0;
    logic [3:0] half0;
    logic       locked1, pv1, mm1, st1;
    logic [3:0] half1;

    blink_monitor #(.TOLERANCE(0)) dut0 (
        .clk(clk), .rst(rst), .blink_in(blink_in),
        .locked(locked0), .half_period(half0), .period_valid(pv0),
        .mismatch(mm0), .stuck(st0)
    );

    blink_monitor #(.TOLERANCE(1)) dut1 (
        .clk(clk), .rst(rst), .blink_in(blink_in),
        .locked(locked1), .half_period(half1), .period_valid(pv1),
        .mismatch(mm1), .stuck(st1)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model state: time of last edge, armed flag, streak of good runs, lock flag.
    int  cyc = 0;
    int  m_last[2]   = '{-100, -100};
    bit  m_prev[2];
    bit  m_armed[2];
    bit  m_locked[2];
    int  m_streak[2];
    int  m_half[2];
    bit  e_pv[2], e_mm[2], e_st[2];

    initial begin : model
        int  tol, run, dev;
        bit  e;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                tol = i;
                e_pv[i] = 1'b0;
                e_mm[i] = 1'b0;
                e_st[i] = 1'b0;
                if (rst) begin
                    m_prev[i] = 1'b0;
                    m_armed[i] = 1'b0;
                    m_locked[i] = 1'b0;
                    m_streak[i] = 0;
                    m_half[i] = 0;
                end else begin
                    e = (blink_in != m_prev[i]);
                    m_prev[i] = blink_in;
                    run = cyc - m_last[i];
                    if (run > SAT) run = SAT;
                    if (e) begin
                        if (m_armed[i]) begin
                            m_half[i] = run;
                            e_pv[i] = 1'b1;
                            dev = (run > EXP_HALF) ? run - EXP_HALF : EXP_HALF - run;
                            if (dev <= tol) begin
                                m_streak[i]++;
                                if (m_streak[i] >= LOCK_N) m_locked[i] = 1'b1;
                            end else begin
                                e_mm[i] = 1'b1;
                                m_streak[i] = 0;
                                m_locked[i] = 1'b0;
                            end
                        end else begin
                            m_armed[i] = 1'b1;
                            m_streak[i] = 0;
                        end
                        m_last[i] = cyc;
                    end else if (m_armed[i] && run == TMO) begin
                        e_st[i] = 1'b1;
                        m_armed[i] = 1'b0;
                        m_locked[i] = 1'b0;
                        m_streak[i] = 0;
                    end
                end
            end
            cyc++;
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin : compare
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("d0.locked",       int'(locked0), int'(m_locked[0]));
            chk("d0.half_period",  int'(half0),   m_half[0]);
            chk("d0.period_valid", int'(pv0),     int'(e_pv[0]));
            chk("d0.mismatch",     int'(mm0),     int'(e_mm[0]));
            chk("d0.stuck",        int'(st0),     int'(e_st[0]));
            chk("d1.locked",       int'(locked1), int'(m_locked[1]));
            chk("d1.half_period",  int'(half1),   m_half[1]);
            chk("d1.period_valid", int'(pv1),     int'(e_pv[1]));
            chk("d1.mismatch",     int'(mm1),     int'(e_mm[1]));
            chk("d1.stuck",        int'(st1),     int'(e_st[1]));
        end
    end

    task automatic tog();
        blink_in = ~blink_in;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Directed stimulus; literal checks sample the negedge right after the relevant edge.
    initial begin : stim
        rst = 1'b1;
        blink_in = 1'b0;
        wait_n(3);
        chk("lit reset locked", int'(locked0), 0);
        chk("lit reset half", int'(half0), 0);
        chk("lit reset pv", int'(pv0), 0);
        rst = 1'b0;
        wait_n(2);

        // Arm plus four runs of 3 -> lock on the fourth measured edge.
        tog(); wait_n(1);
        chk("lit arm pv", int'(pv0), 0);
        wait_n(2);
        for (int k = 0; k < 3; k++) begin tog(); wait_n(3); end
        tog(); wait_n(1);
        chk("lit lock pv", int'(pv0), 1);
        chk("lit lock half", int'(half0), 3);
        chk("lit lock locked", int'(locked0), 1);
        chk("lit lock mm", int'(mm0), 0);
        wait_n(3);

        // One run of 4 breaks lock at tolerance 0 only.
        tog(); wait_n(1);
        chk("lit run4 half", int'(half0), 4);
        chk("lit run4 mm", int'(mm0), 1);
        chk("lit run4 locked", int'(locked0), 0);
        chk("lit run4 tol1 locked", int'(locked1), 1);
        wait_n(2);

        // Four runs of 3 relock.
        for (int k = 0; k < 3; k++) begin tog(); wait_n(3); end
        tog(); wait_n(1);
        chk("lit relock", int'(locked0), 1);

        // Hold the line: stuck fires 9 cycles after the last edge, once.
        wait_n(7);
        chk("lit pre-stuck st", int'(st0), 0);
        chk("lit pre-stuck locked", int'(locked0), 1);
        wait_n(1);
        chk("lit stuck st", int'(st0), 1);
        chk("lit stuck locked", int'(locked0), 0);
        chk("lit stuck tol1", int'(st1), 1);
        wait_n(20);
        chk("lit stuck once", int'(st0), 0);

        // Run of exactly 8: the edge wins over timeout.
        tog(); wait_n(8);
        tog(); wait_n(1);
        chk("lit run8 pv", int'(pv0), 1);
        chk("lit run8 half", int'(half0), 8);
        chk("lit run8 mm", int'(mm0), 1);
        chk("lit run8 st", int'(st0), 0);
        wait_n(2);

        // Relock, then a single-cycle reset while locked.
        for (int k = 0; k < 3; k++) begin tog(); wait_n(3); end
        tog(); wait_n(1);
        chk("lit relock2", int'(locked0), 1);
        rst = 1'b1;
        blink_in = 1'b1;
        wait_n(1);
        chk("lit rst locked", int'(locked0), 0);
        chk("lit rst half", int'(half0), 0);
        chk("lit rst pv", int'(pv0), 0);
        chk("lit rst mm", int'(mm0), 0);
        chk("lit rst st", int'(st0), 0);
        rst = 1'b0;
        // Line high at release is the arming edge: no measurement.
        wait_n(1);
        chk("lit rearm pv", int'(pv0), 0);
        chk("lit rearm locked", int'(locked0), 0);
        wait_n(1);

        // Runs alternating 2 and 4: tolerance 1 locks, tolerance 0 keeps mismatching.
        tog(); wait_n(4);
        tog(); wait_n(2);
        tog(); wait_n(4);
        tog(); wait_n(1);
        chk("lit alt tol1 locked", int'(locked1), 1);
        chk("lit alt tol1 half", int'(half1), 4);
        chk("lit alt tol0 locked", int'(locked0), 0);
        chk("lit alt tol0 mm", int'(mm0), 1);
        chk("lit alt tol0 half", int'(half0), 4);
        wait_n(1);

        // Back-to-back short runs, then let the line go stuck.
        tog(); wait_n(1);
        tog(); wait_n(1);
        tog(); wait_n(12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
